// File: rtl/glitch_sequencer.sv
// Arms on command, waits for a synchronized target trigger edge, counts a delay,
// then strobes the pulser with config latched at arm time and waits for completion.
module glitch_sequencer #(
  parameter int unsigned DELAY_W = 24,
  parameter int unsigned TO_W    = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic               auto_rearm_i,
  input  logic               trigger_i,
  input  logic               trig_pol_i,
  input  logic [DELAY_W-1:0] delay_i,
  input  logic [7:0]         pulse_width_i,
  input  logic [7:0]         num_pulses_i,
  input  logic [15:0]        pulse_spacing_i,
  input  logic               pulser_ready_i,
  output logic               pulser_en_o,
  output logic [7:0]         pulse_width_o,
  output logic [7:0]         num_pulses_o,
  output logic [15:0]        pulse_spacing_o,
  output logic               armed_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [7:0]         glitch_count_o
);

  localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - TO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_FIRE, S_WAIT_DONE, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               sync1_q, sync2_q, hist_q;
  logic [DELAY_W-1:0] delay_lat_q, delay_lat_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic [TO_W-1:0]    tocnt_q, tocnt_d;
  logic [7:0]         pw_q, pw_d;
  logic [7:0]         np_q, np_d;
  logic [15:0]        ps_q, ps_d;
  logic               en_q, en_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         gcount_q, gcount_d;
  logic               armed_q, armed_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               trig_edge_c;

  // Synchronizer idles at the inactive level so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= ~trig_pol_i;
      sync2_q <= ~trig_pol_i;
      hist_q  <= ~trig_pol_i;
    end else begin
      sync1_q <= trigger_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign trig_edge_c = trig_pol_i ? (sync2_q & ~hist_q) : (~sync2_q & hist_q);

  always_comb begin
    state_d     = state_q;
    delay_lat_d = delay_lat_q;
    dcnt_d      = dcnt_q;
    tocnt_d     = tocnt_q;
    pw_d        = pw_q;
    np_d        = np_q;
    ps_d        = ps_q;
    timeout_d   = timeout_q;
    gcount_d    = gcount_q;
    if (abort_i) begin
      state_d = S_IDLE;
      dcnt_d  = '0;
      tocnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            state_d     = S_ARMED;
            delay_lat_d = delay_i;
            pw_d        = pulse_width_i;
            np_d        = num_pulses_i;
            ps_d        = pulse_spacing_i;
            timeout_d   = 1'b0;
          end
        end
        S_ARMED: begin
          if (trig_edge_c) begin
            state_d = (delay_lat_q == '0) ? S_FIRE : S_DELAY;
            dcnt_d  = delay_lat_q;
          end
        end
        S_DELAY: begin
          dcnt_d = dcnt_q - DELAY_W'(1);
          if (dcnt_q == DELAY_W'(1)) state_d = S_FIRE;
        end
        S_FIRE: begin
          tocnt_d = '0;
          if (pulser_ready_i) state_d = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          tocnt_d = tocnt_q + TO_W'(1);
          // Ready seen high after the first cycle means the train has finished.
          if (pulser_ready_i && (tocnt_q != '0)) begin
            state_d  = auto_rearm_i ? S_ARMED : S_DONE;
            tocnt_d  = '0;
            gcount_d = (gcount_q == 8'hFF) ? gcount_q : gcount_q + 8'd1;
          end else if (tocnt_q == TO_LAST) begin
            state_d   = S_IDLE;
            tocnt_d   = '0;
            timeout_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    en_d    = (state_q == S_FIRE) && !abort_i;
    armed_d = (state_d == S_ARMED);
    busy_d  = (state_d == S_DELAY) || (state_d == S_FIRE) || (state_d == S_WAIT_DONE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      delay_lat_q <= '0;
      dcnt_q      <= '0;
      tocnt_q     <= '0;
      pw_q        <= '0;
      np_q        <= '0;
      ps_q        <= '0;
      en_q        <= 1'b0;
      timeout_q   <= 1'b0;
      gcount_q    <= '0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_lat_q <= delay_lat_d;
      dcnt_q      <= dcnt_d;
      tocnt_q     <= tocnt_d;
      pw_q        <= pw_d;
      np_q        <= np_d;
      ps_q        <= ps_d;
      en_q        <= en_d;
      timeout_q   <= timeout_d;
      gcount_q    <= gcount_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pulser_en_o     = en_q;
  assign pulse_width_o   = pw_q;
  assign num_pulses_o    = np_q;
  assign pulse_spacing_o = ps_q;
  assign armed_o         = armed_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign timeout_o       = timeout_q;
  assign glitch_count_o  = gcount_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboarded bench for glitch_sequencer: strobe timing/config checked by a monitor,
// state flags and counters checked inline against hand-computed values.
module tb_glitch_sequencer;

  localparam int unsigned DELAY_W = 24;
  localparam int unsigned TO_W    = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               arm_i, abort_i, auto_rearm_i, trigger_i, trig_pol_i;
  logic [DELAY_W-1:0] delay_i;
  logic [7:0]         pulse_width_i, num_pulses_i;
  logic [15:0]        pulse_spacing_i;
  logic               pulser_ready_i;
  logic               pulser_en_o;
  logic [7:0]         pulse_width_o, num_pulses_o;
  logic [15:0]        pulse_spacing_o;
  logic               armed_o, busy_o, done_o, timeout_o;
  logic [7:0]         glitch_count_o;

  glitch_sequencer #(.DELAY_W(DELAY_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .abort_i(abort_i),
    .auto_rearm_i(auto_rearm_i), .trigger_i(trigger_i), .trig_pol_i(trig_pol_i),
    .delay_i(delay_i), .pulse_width_i(pulse_width_i), .num_pulses_i(num_pulses_i),
    .pulse_spacing_i(pulse_spacing_i), .pulser_ready_i(pulser_ready_i),
    .pulser_en_o(pulser_en_o), .pulse_width_o(pulse_width_o),
    .num_pulses_o(num_pulses_o), .pulse_spacing_o(pulse_spacing_o),
    .armed_o(armed_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .glitch_count_o(glitch_count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model pulser: drops ready for a few cycles after a start; hang keeps it low.
  logic hang = 1'b0;
  int   bcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulser_ready_i <= 1'b1;
      bcnt           <= 0;
    end else if (pulser_en_o && pulser_ready_i) begin
      pulser_ready_i <= 1'b0;
      bcnt           <= 4;
    end else if (!pulser_ready_i && !hang) begin
      if (bcnt == 0) pulser_ready_i <= 1'b1;
      else           bcnt <= bcnt - 1;
    end
  end

  typedef struct {
    int        cyc;
    int        width;
    int        w;
    int        n;
    int        s;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic prev_en = 1'b0;
  int   hi_cnt  = 0;

  // Monitor: each strobe rising edge pops one expectation.
  always @(negedge clk) begin
    if (pulser_en_o && !prev_en) begin
      hi_cnt = 1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: strobe at cycle %0d, none expected", cyc);
        cur.width = 1;
      end else begin
        cur = sb.pop_front();
        chk("strobe_cycle", cyc, cur.cyc);
        chk("strobe_width_cfg", int'(pulse_width_o), cur.w);
        chk("strobe_num_cfg", int'(num_pulses_o), cur.n);
        chk("strobe_spacing_cfg", int'(pulse_spacing_o), cur.s);
      end
    end else if (pulser_en_o) begin
      hi_cnt++;
    end else if (prev_en) begin
      chk("strobe_len", hi_cnt, cur.width);
    end
    prev_en = pulser_en_o;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm_seq(input int d, input int w, input int n, input int s);
    @(negedge clk);
    delay_i         = DELAY_W'(d);
    pulse_width_i   = 8'(w);
    num_pulses_i    = 8'(n);
    pulse_spacing_i = 16'(s);
    arm_i           = 1'b1;
    @(negedge clk);
    arm_i = 1'b0;
  endtask

  task automatic set_trig(input logic lvl, output int t0);
    @(negedge clk);
    trigger_i = lvl;
    t0 = cyc + 1;
  endtask

  task automatic push(input int c, input int w, input int n, input int s);
    exp_t e;
    e.cyc = c; e.width = 1; e.w = w; e.n = n; e.s = s;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_o) break;
    end
    chk(name, int'(done_o), 1);
  endtask

  task automatic abort_pulse();
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, int'(pulser_en_o), 0);
    chk({tag, "_pw"}, int'(pulse_width_o), 0);
    chk({tag, "_np"}, int'(num_pulses_o), 0);
    chk({tag, "_ps"}, int'(pulse_spacing_o), 0);
    chk({tag, "_armed"}, int'(armed_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_timeout"}, int'(timeout_o), 0);
    chk({tag, "_count"}, int'(glitch_count_o), 0);
  endtask

  int t0;

  initial begin
    rst_n = 1'b0; arm_i = 1'b0; abort_i = 1'b0; auto_rearm_i = 1'b0;
    trigger_i = 1'b0; trig_pol_i = 1'b1; delay_i = '0;
    pulse_width_i = '0; num_pulses_i = '0; pulse_spacing_i = '0;
    tick(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(3);

    // Basic glitch: delay 10, rising edge.
    arm_seq(10, 5, 3, 20);
    chk("a_armed", int'(armed_o), 1);
    chk("a_pw", int'(pulse_width_o), 5);
    set_trig(1'b1, t0);
    push(t0 + 13, 5, 3, 20);
    wait_done("a_done", 100);
    chk("a_count", int'(glitch_count_o), 1);
    chk("a_busy", int'(busy_o), 0);
    chk("a_np", int'(num_pulses_o), 3);
    chk("a_ps", int'(pulse_spacing_o), 20);
    set_trig(1'b0, t0);
    tick(4);

    // Falling-edge trigger with zero delay; rising edge while armed is ignored.
    trig_pol_i = 1'b0;
    tick(4);
    arm_seq(0, 2, 1, 7);
    set_trig(1'b1, t0);
    tick(6);
    chk("b_rise_ignored_armed", int'(armed_o), 1);
    chk("b_rise_ignored_busy", int'(busy_o), 0);
    set_trig(1'b0, t0);
    push(t0 + 3, 2, 1, 7);
    wait_done("b_done", 100);
    chk("b_count", int'(glitch_count_o), 2);

    // Auto-rearm across four triggers; config inputs changed after arm.
    trig_pol_i   = 1'b1;
    auto_rearm_i = 1'b1;
    tick(4);
    arm_seq(2, 9, 4, 11);
    pulse_width_i = 8'd77;
    for (int k = 0; k < 4; k++) begin
      set_trig(1'b1, t0);
      push(t0 + 5, 9, 4, 11);
      tick(30);
      chk("c_armed", int'(armed_o), 1);
      chk("c_count", int'(glitch_count_o), 3 + k);
      chk("c_pw_held", int'(pulse_width_o), 9);
      set_trig(1'b0, t0);
      tick(4);
    end
    auto_rearm_i = 1'b0;
    abort_pulse();
    chk("c_abort_armed", int'(armed_o), 0);
    chk("c_abort_count", int'(glitch_count_o), 6);

    // Completion timeout: pulser never returns ready.
    arm_seq(0, 1, 1, 1);
    hang = 1'b1;
    set_trig(1'b1, t0);
    push(t0 + 3, 1, 1, 1);
    while (cyc < t0 + 17) @(negedge clk);
    chk("d_pre_timeout", int'(timeout_o), 0);
    chk("d_pre_busy", int'(busy_o), 1);
    @(negedge clk);
    chk("d_timeout", int'(timeout_o), 1);
    chk("d_busy", int'(busy_o), 0);
    chk("d_done", int'(done_o), 0);
    chk("d_armed", int'(armed_o), 0);
    chk("d_count", int'(glitch_count_o), 6);
    hang = 1'b0;
    set_trig(1'b0, t0);
    tick(10);

    // Rearm clears timeout; abort during DELAY at count 5.
    arm_seq(8, 2, 2, 2);
    chk("e_timeout_cleared", int'(timeout_o), 0);
    set_trig(1'b1, t0);
    while (cyc < t0 + 5) @(negedge clk);
    chk("e_in_delay", int'(busy_o), 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("e_abort_busy", int'(busy_o), 0);
    chk("e_abort_armed", int'(armed_o), 0);
    tick(20);
    chk("e_count", int'(glitch_count_o), 6);

    // Abort wins over arm in IDLE; triggers in IDLE are dropped.
    @(negedge clk);
    arm_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    arm_i = 1'b0; abort_i = 1'b0;
    chk("f_abort_over_arm", int'(armed_o), 0);
    set_trig(1'b0, t0);
    tick(3);
    set_trig(1'b1, t0);
    tick(10);
    chk("f_idle_busy", int'(busy_o), 0);
    chk("f_idle_count", int'(glitch_count_o), 6);

    // Reset in the middle of a long delay.
    set_trig(1'b0, t0);
    tick(4);
    arm_seq(1000, 3, 3, 3);
    set_trig(1'b1, t0);
    tick(10);
    chk("g_in_delay", int'(busy_o), 1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("g_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(1100);
    chk("g_post_busy", int'(busy_o), 0);
    chk("g_post_armed", int'(armed_o), 0);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
